// File: rtl/csync_decoder.sv
// Composite sync receiver: splits an active-low CSYNC into line/field strobes,
// beam counters and a line-timing lock indication, all on CLOCK_24.
module csync_decoder #(
    parameter logic [10:0] HS_MIN     = 11'd48,
    parameter logic [10:0] VS_MIN     = 11'd384,
    parameter logic [10:0] LINE_MIN   = 11'd1440,
    parameter logic [10:0] LINE_MAX   = 11'd1632,
    parameter logic [3:0]  LOCK_LINES = 4'd8
) (
    input  logic        CLOCK_24,
    input  logic        nRESET,
    input  logic        CSYNC,
    output logic        HS_PULSE,
    output logic        VS_PULSE,
    output logic        VBLANK,
    output logic [10:0] X_COUNT,
    output logic [8:0]  Y_COUNT,
    output logic [10:0] LINE_PERIOD,
    output logic        LOCKED
);

    typedef enum logic {S_HIGH = 1'b0, S_LOW = 1'b1} state_t;

    logic        s1_r, s2_r, s3_r;
    logic [1:0]  warm_r;
    logic        armed_r;
    state_t      state_r;
    logic [10:0] low_cnt_r;
    logic        broad_run_r;
    logic        hs_det_r, vs_det_r, hs_exempt_r;
    logic [10:0] period_cnt_r;
    logic [3:0]  good_cnt_r;

    logic        fall_s, rise_s, period_win_s;
    logic [10:0] period_inc_s, x_inc_s;
    logic [8:0]  y_inc_s;
    logic [3:0]  good_inc_s;

    // Edge detection and saturating increments shared by the sequential blocks.
    always_comb begin
        fall_s       = s3_r & ~s2_r;
        rise_s       = ~s3_r & s2_r;
        period_inc_s = (period_cnt_r == 11'd2047) ? 11'd2047 : period_cnt_r + 11'd1;
        x_inc_s      = (X_COUNT == 11'd2047) ? 11'd2047 : X_COUNT + 11'd1;
        y_inc_s      = (Y_COUNT == 9'd511) ? 9'd511 : Y_COUNT + 9'd1;
        good_inc_s   = (good_cnt_r >= LOCK_LINES) ? LOCK_LINES : good_cnt_r + 4'd1;
        period_win_s = (period_cnt_r >= LINE_MIN) && (period_cnt_r <= LINE_MAX);
    end

    // Two-stage synchroniser plus edge register, idling high.
    always_ff @(posedge CLOCK_24 or negedge nRESET) begin
        if (!nRESET) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
            s3_r <= 1'b1;
        end else begin
            s1_r <= CSYNC;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Arm only after a genuinely sampled high, so a pulse already low at reset release is skipped.
    always_ff @(posedge CLOCK_24 or negedge nRESET) begin
        if (!nRESET) begin
            warm_r  <= 2'd0;
            armed_r <= 1'b0;
        end else begin
            if (warm_r != 2'd2) begin
                warm_r <= warm_r + 2'd1;
            end
            armed_r <= armed_r | ((warm_r == 2'd2) & s2_r);
        end
    end

    // Pulse-width FSM: measures each low pulse and classifies it on the rising edge.
    always_ff @(posedge CLOCK_24 or negedge nRESET) begin
        if (!nRESET) begin
            state_r     <= S_HIGH;
            low_cnt_r   <= 11'd0;
            broad_run_r <= 1'b0;
            hs_det_r    <= 1'b0;
            vs_det_r    <= 1'b0;
            hs_exempt_r <= 1'b0;
        end else begin
            hs_det_r <= 1'b0;
            vs_det_r <= 1'b0;
            case (state_r)
                S_HIGH: begin
                    if (fall_s && armed_r) begin
                        state_r   <= S_LOW;
                        low_cnt_r <= 11'd1;
                    end
                end
                S_LOW: begin
                    if (rise_s) begin
                        state_r <= S_HIGH;
                        if (low_cnt_r >= VS_MIN) begin
                            vs_det_r    <= ~broad_run_r;
                            broad_run_r <= 1'b1;
                        end else if (low_cnt_r >= HS_MIN) begin
                            hs_det_r    <= 1'b1;
                            hs_exempt_r <= broad_run_r;
                            broad_run_r <= 1'b0;
                        end
                    end else if (low_cnt_r != 11'd2047) begin
                        low_cnt_r <= low_cnt_r + 11'd1;
                    end
                end
                default: state_r <= S_HIGH;
            endcase
        end
    end

    // Strobes, beam counters, period measurement and lock tracking.
    always_ff @(posedge CLOCK_24 or negedge nRESET) begin
        if (!nRESET) begin
            HS_PULSE     <= 1'b0;
            VS_PULSE     <= 1'b0;
            VBLANK       <= 1'b0;
            X_COUNT      <= 11'd0;
            Y_COUNT      <= 9'd0;
            LINE_PERIOD  <= 11'd0;
            LOCKED       <= 1'b0;
            period_cnt_r <= 11'd0;
            good_cnt_r   <= 4'd0;
        end else begin
            HS_PULSE <= hs_det_r;
            VS_PULSE <= vs_det_r;
            if (hs_det_r) begin
                X_COUNT      <= 11'd0;
                period_cnt_r <= 11'd1;
                LINE_PERIOD  <= period_cnt_r;
                Y_COUNT      <= y_inc_s;
                VBLANK       <= 1'b0;
                // The line closing a vertical interval has an irregular period; skip it.
                if (!hs_exempt_r) begin
                    if (period_win_s) begin
                        good_cnt_r <= good_inc_s;
                        if (good_inc_s == LOCK_LINES) begin
                            LOCKED <= 1'b1;
                        end
                    end else begin
                        good_cnt_r <= 4'd0;
                        LOCKED     <= 1'b0;
                    end
                end
            end else begin
                X_COUNT      <= x_inc_s;
                period_cnt_r <= period_inc_s;
                if (vs_det_r) begin
                    Y_COUNT <= 9'd0;
                    VBLANK  <= 1'b1;
                end
                if (period_inc_s == 11'd2047) begin
                    good_cnt_r <= 4'd0;
                    LOCKED     <= 1'b0;
                end
            end
        end
    end

endmodule
